// File: rtl/midi_tx_pkg.sv
// midi_tx_pkg: shared transmitter state encoding and MIDI frame constants
package midi_tx_pkg;
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;
  localparam int MIDI_BAUD_DIV = 3200;
  localparam int FRAME_DATA_BITS = 8;
endpackage

// File: rtl/midi_tx_baud_timer.sv
// baud_timer: modulo-BAUD_DIV bit timer (CLK, async CLR, CE, sync RESTART in; TC end-of-bit strobe out)
module baud_timer import midi_tx_pkg::*; #(
  parameter int BAUD_DIV = MIDI_BAUD_DIV,
  parameter int W_DIV = 12
) (
  input  logic CLK,
  input  logic CLR,
  input  logic CE,
  input  logic RESTART,
  output logic TC
);
  logic [W_DIV-1:0] q_q, q_d;
  assign TC = CE & (q_q == W_DIV'(BAUD_DIV - 1));
  always_comb q_d = !CE ? q_q : (RESTART || TC) ? '0 : q_q + 1'b1;
  always_ff @(posedge CLK or posedge CLR)
    if (CLR) q_q <= '0;
    else q_q <= q_d;
endmodule

// File: rtl/midi_tx.sv
// midi_tx: 8N1 serial byte transmitter (CLK, async CLR, CE, DATA/VALID in; READY, TXD, BUSY out)
module midi_tx import midi_tx_pkg::*; #(
  parameter int BAUD_DIV = MIDI_BAUD_DIV,
  parameter int W_DIV = 12,
  parameter int STOP_BITS = 1
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       CE,
  input  logic [7:0] DATA,
  input  logic       VALID,
  output logic       READY,
  output logic       TXD,
  output logic       BUSY
);
  state_e state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] idx_q, idx_d;
  logic stop_q, stop_d, txd_q, txd_d, busy_q, busy_d, tc;
  baud_timer #(.BAUD_DIV(BAUD_DIV), .W_DIV(W_DIV)) u_timer (
    .CLK(CLK), .CLR(CLR), .CE(CE), .RESTART(state_q == S_IDLE), .TC(tc)
  );
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d = idx_q;
    stop_d = stop_q;
    txd_d = txd_q;
    case (state_q)
      S_IDLE: if (CE && VALID) begin
        state_d = S_START;
        shift_d = DATA;
        txd_d = 1'b0;
      end
      S_START: if (tc) begin
        state_d = S_DATA;
        idx_d = '0;
        txd_d = shift_q[0];
      end
      S_DATA: if (tc) begin
        shift_d = shift_q >> 1;
        idx_d = idx_q + 1'b1;
        txd_d = (idx_q == 3'(FRAME_DATA_BITS - 1)) ? 1'b1 : shift_q[1];
        state_d = (idx_q == 3'(FRAME_DATA_BITS - 1)) ? S_STOP : S_DATA;
        stop_d = 1'b0;
      end
      S_STOP: if (tc) begin
        stop_d = 1'b1;
        state_d = (stop_q == 1'(STOP_BITS - 1)) ? S_IDLE : S_STOP;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = state_d != S_IDLE;
  end
  always_ff @(posedge CLK or posedge CLR)
    if (CLR) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      idx_q <= '0;
      stop_q <= 1'b0;
      txd_q <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q <= idx_d;
      stop_q <= stop_d;
      txd_q <= txd_d;
      busy_q <= busy_d;
    end
  assign READY = state_q == S_IDLE;
  assign TXD = txd_q;
  assign BUSY = busy_q;
endmodule

// File: tb/tb_midi_tx.sv
// tb_midi_tx: randomized self-checking bench for midi_tx against a cycle-level frame model
module tb_midi_tx;
  localparam int B = 4;
  logic CLK = 1'b0, CLR = 1'b1, CE = 1'b1;
  logic [7:0] DATA = 8'h00;
  logic valid1 = 1'b0, valid2 = 1'b0;
  logic ready1, txd1, busy1, ready2, txd2, busy2;
  int checks = 0, passed = 0;
  midi_tx #(.BAUD_DIV(B), .W_DIV(3), .STOP_BITS(1)) dut1 (
    .CLK(CLK), .CLR(CLR), .CE(CE), .DATA(DATA), .VALID(valid1),
    .READY(ready1), .TXD(txd1), .BUSY(busy1)
  );
  midi_tx #(.BAUD_DIV(B), .W_DIV(3), .STOP_BITS(2)) dut2 (
    .CLK(CLK), .CLR(CLR), .CE(CE), .DATA(DATA), .VALID(valid2),
    .READY(ready2), .TXD(txd2), .BUSY(busy2)
  );
  always #5 CLK = ~CLK;
  task automatic play(input bit sel, input logic [7:0] d, input bit hold, input logic [7:0] mid, input int gap_len);
    int stop;
    logic [10:0] frame;
    logic t, r, b;
    stop = sel ? 2 : 1;
    frame = {2'b11, d, 1'b0};
    @(negedge CLK);
    t = sel ? txd2 : txd1;
    r = sel ? ready2 : ready1;
    b = sel ? busy2 : busy1;
    checks++;
    if (t !== 1'b1 || r !== 1'b1 || b !== 1'b0)
      $display("FAIL idle before 0x%02h: txd=%b ready=%b busy=%b, want 1/1/0", d, t, r, b);
    else passed++;
    DATA = d;
    CE = 1'b1;
    if (sel) valid2 = 1'b1; else valid1 = 1'b1;
    for (int p = 0; p < 9 + stop; p++)
      for (int c = 0; c < B; c++) begin
        int n;
        n = (p == 3 && c == 1) ? gap_len + 1 : 1;
        for (int g = 0; g < n; g++) begin
          @(negedge CLK);
          t = sel ? txd2 : txd1;
          r = sel ? ready2 : ready1;
          b = sel ? busy2 : busy1;
          checks++;
          if (t !== frame[p] || r !== 1'b0 || b !== 1'b1)
            $display("FAIL frame 0x%02h bit %0d cyc %0d: txd=%b ready=%b busy=%b, want %b/0/1", d, p, c, t, r, b, frame[p]);
          else passed++;
          DATA = mid;
          if (sel) valid2 = hold; else valid1 = hold;
          CE = (g < n - 1) ? 1'b0 : 1'b1;
        end
      end
  endtask
  task automatic test_reset;
    #12;
    checks++;
    if (txd1 !== 1'b1 || ready1 !== 1'b1 || busy1 !== 1'b0 || txd2 !== 1'b1 || ready2 !== 1'b1 || busy2 !== 1'b0)
      $display("FAIL reset: txd=%b%b ready=%b%b busy=%b%b, want 11/11/00", txd1, txd2, ready1, ready2, busy1, busy2);
    else passed++;
    @(negedge CLK);
    CLR = 1'b0;
    repeat (2) @(negedge CLK);
  endtask
  task automatic test_reset_mid_frame;
    @(negedge CLK);
    DATA = 8'h90;
    valid1 = 1'b1;
    @(negedge CLK);
    valid1 = 1'b0;
    repeat (4 * B) @(negedge CLK);
    checks++;
    if (txd1 !== 1'b0 || busy1 !== 1'b1)
      $display("FAIL mid-frame bit3: txd=%b busy=%b, want 0/1", txd1, busy1);
    else passed++;
    #2 CLR = 1'b1;
    #1;
    checks++;
    if (txd1 !== 1'b1 || ready1 !== 1'b1 || busy1 !== 1'b0)
      $display("FAIL async clear: txd=%b ready=%b busy=%b, want 1/1/0", txd1, ready1, busy1);
    else passed++;
    @(negedge CLK);
    CLR = 1'b0;
    play(1'b0, 8'h90, 1'b0, 8'h90, 0);
  endtask
  task automatic test_single;
    play(1'b0, 8'h90, 1'b0, 8'h00, 0);
  endtask
  task automatic test_back_to_back;
    play(1'b0, 8'h90, 1'b1, 8'h3C, 0);
    play(1'b0, 8'h3C, 1'b0, 8'h00, 0);
  endtask
  task automatic test_hold_off;
    play(1'b0, 8'h90, 1'b0, 8'hFF, 0);
    play(1'b0, 8'h00, 1'b1, 8'h00, 0);
    play(1'b0, 8'h00, 1'b0, 8'hFF, 0);
  endtask
  task automatic test_ce_gating;
    play(1'b0, 8'h90, 1'b0, 8'h00, 7);
  endtask
  task automatic test_two_stop_bits;
    play(1'b1, 8'h00, 1'b0, 8'h00, 0);
    @(negedge CLK);
    checks++;
    if (ready2 !== 1'b1 || busy2 !== 1'b0 || txd2 !== 1'b1)
      $display("FAIL two-stop end: ready=%b busy=%b txd=%b, want 1/0/1", ready2, busy2, txd2);
    else passed++;
  endtask
  task automatic test_random;
    logic [7:0] bytes [8];
    bit hold;
    for (int i = 0; i < 8; i++) bytes[i] = 8'($urandom);
    for (int i = 0; i < 8; i++) begin
      hold = (i < 7) && ($urandom_range(0, 1) == 1);
      play(1'b0, bytes[i], hold, hold ? bytes[i + 1] : 8'($urandom), $urandom_range(0, 3));
    end
    @(negedge CLK);
    checks++;
    if (ready1 !== 1'b1 || busy1 !== 1'b0 || txd1 !== 1'b1)
      $display("FAIL random end: ready=%b busy=%b txd=%b, want 1/0/1", ready1, busy1, txd1);
    else passed++;
  endtask
  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_hold_off;
    test_ce_gating;
    test_reset_mid_frame;
    test_two_stop_bits;
    test_random;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
